incr_rr_arbiter: RTL and testbench

- Shares one combinational n_bit_one_adder (A + cin) among R requesters.
- Arbitration is round-robin over valid requesters.
- Each granted operation is registered into a single output slot with a valid/ready handshake.
- Sits between MAC-side counter/address clients and the shared incrementer cell; one result per cycle at full throughput.

---
 rtl/incr_rr_arbiter_pkg.sv | 22 ++
 rtl/incr_rr_arbiter_if.sv | 29 ++
 rtl/incr_rr_arbiter_rr_grant.sv | 35 +++
 rtl/n_bit_one_adder.sv | 11 +
 rtl/incr_rr_arbiter.sv | 109 ++++++++++
 tb/tb_incr_rr_arbiter.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/incr_rr_arbiter_pkg.sv
// Shared definitions for the round-robin incrementer arbiter.
// The optional saturation mode is selected with INCR_RR_ARBITER_SATURATE_EN.
package incr_rr_arbiter_pkg;

   localparam int RR_PTR_RST = 0;

   // A single requester still needs a 1-bit id/pointer field.
   function automatic int id_w(input int r);
      int w;
      w = $clog2(r);
      return (w < 1) ? 1 : w;
   endfunction

   // Response record at the block's default geometry (N=8, R=4); the top
   // builds the same layout from its own parameters.
   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic [1:0] id;
   } resp_t;

endpackage

// File: rtl/incr_rr_arbiter_if.sv
// Request/response bus between incrementer clients and incr_rr_arbiter.
// master = client side, slave = arbiter side.
interface incr_rr_arbiter_if
   import incr_rr_arbiter_pkg::*;
#(
   parameter int N   = 8,
   parameter int R   = 4,
   parameter int IDW = id_w(R)
);
   logic [R-1:0]   req_valid;
   logic [R*N-1:0] req_a;
   logic [R-1:0]   req_cin;
   logic [R-1:0]   req_ready;
   logic           resp_valid;
   logic           resp_ready;
   logic [N-1:0]   resp_sum;
   logic           resp_cout;
   logic [IDW-1:0] resp_id;

   modport master (
      output req_valid, req_a, req_cin, resp_ready,
      input  req_ready, resp_valid, resp_sum, resp_cout, resp_id
   );

   modport slave (
      input  req_valid, req_a, req_cin, resp_ready,
      output req_ready, resp_valid, resp_sum, resp_cout, resp_id
   );
endinterface

// File: rtl/incr_rr_arbiter_rr_grant.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr_i,
// wrapping modulo R; produces a one-hot grant and its encoded index.
module rr_grant #(
   parameter int R   = 4,
   parameter int IDW = 2
) (
   input  logic [R-1:0]   req_valid_i,
   input  logic [IDW-1:0] rr_ptr_i,
   output logic [R-1:0]   gnt_oh_o,
   output logic [IDW-1:0] gnt_idx_o,
   output logic           gnt_vld_o
);
   int             j;
   logic [IDW-1:0] idx;

   // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
   always_comb begin
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      j         = 0;
      idx       = '0;
      for (int k = R - 1; k >= 0; k--) begin
         j = int'(rr_ptr_i) + k;
         if (j >= R) j = j - R;
         idx = IDW'(j);
         if (req_valid_i[idx]) begin
            gnt_oh_o      = '0;
            gnt_oh_o[idx] = 1'b1;
            gnt_idx_o     = idx;
            gnt_vld_o     = 1'b1;
         end
      end
   end
endmodule

// File: rtl/n_bit_one_adder.sv
// Combinational N-bit incrementer cell: {cout, SUM} = A + cin.
module n_bit_one_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] A,
   input  logic         cin,
   output logic [N-1:0] SUM,
   output logic         cout
);
   assign {cout, SUM} = {1'b0, A} + {{N{1'b0}}, cin};
endmodule

// File: rtl/incr_rr_arbiter.sv
// Round-robin arbiter sharing one n_bit_one_adder among R requesters, with a
// single registered result slot. Optional: INCR_RR_ARBITER_SATURATE_EN.
module incr_rr_arbiter
   import incr_rr_arbiter_pkg::*;
#(
   parameter int N     = 8,
   parameter int R     = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   incr_rr_arbiter_if.slave bus,
   output logic [CNT_W-1:0] op_count
`ifdef INCR_RR_ARBITER_SATURATE_EN
   ,
   output logic             sat_flag
`endif
);
   localparam int IDW = id_w(R);

   typedef struct packed {
      logic [N-1:0]   sum;
      logic           cout;
      logic [IDW-1:0] id;
   } slot_t;

   slot_t            resp_q, resp_d;
   logic             resp_valid_q;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] op_count_q;

   logic [R-1:0]     gnt_oh;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_vld;
   logic             slot_free, accept, drain;
   logic [N-1:0]     a_sel, add_sum;
   logic             cin_sel, add_cout;

   rr_grant #(.R(R), .IDW(IDW)) u_grant (
      .req_valid_i (bus.req_valid),
      .rr_ptr_i    (rr_ptr_q),
      .gnt_oh_o    (gnt_oh),
      .gnt_idx_o   (gnt_idx),
      .gnt_vld_o   (gnt_vld)
   );

   assign slot_free     = !resp_valid_q || bus.resp_ready;
   assign accept        = slot_free && gnt_vld;
   assign drain         = resp_valid_q && bus.resp_ready;
   assign bus.req_ready = accept ? gnt_oh : '0;

   assign a_sel   = bus.req_a[gnt_idx*N +: N];
   assign cin_sel = bus.req_cin[gnt_idx];

   n_bit_one_adder #(.N(N)) u_add (
      .A    (a_sel),
      .cin  (cin_sel),
      .SUM  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      resp_d.cout = add_cout;
      resp_d.id   = gnt_idx;
`ifdef INCR_RR_ARBITER_SATURATE_EN
      resp_d.sum  = add_cout ? '1 : add_sum;
`else
      resp_d.sum  = add_sum;
`endif
      rr_ptr_d    = (int'(gnt_idx) == R - 1) ? '0 : gnt_idx + IDW'(1);
   end

   // A simultaneous drain and accept simply overwrites the slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_q       <= '0;
         resp_valid_q <= 1'b0;
         rr_ptr_q     <= IDW'(RR_PTR_RST);
         op_count_q   <= '0;
      end else begin
         if (accept) begin
            resp_q       <= resp_d;
            resp_valid_q <= 1'b1;
            rr_ptr_q     <= rr_ptr_d;
         end else if (drain) begin
            resp_valid_q <= 1'b0;
         end
         if (drain) op_count_q <= op_count_q + CNT_W'(1);
      end
   end

`ifdef INCR_RR_ARBITER_SATURATE_EN
   logic sat_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       sat_q <= 1'b0;
      else if (accept) sat_q <= add_cout;
      else if (drain)  sat_q <= 1'b0;
   end

   assign sat_flag = sat_q;
`endif

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_sum   = resp_q.sum;
   assign bus.resp_cout  = resp_q.cout;
   assign bus.resp_id    = resp_q.id;
   assign op_count       = op_count_q;
endmodule

// File: tb/tb_incr_rr_arbiter.sv
// Directed self-checking bench for incr_rr_arbiter (N=8, R=4, CNT_W=16).
module tb_incr_rr_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] op_count;
`ifdef INCR_RR_ARBITER_SATURATE_EN
   logic        sat_flag;
`endif
   int n_checks = 0;
   int n_fail   = 0;

   incr_rr_arbiter_if #(.N(8), .R(4)) bus ();

   incr_rr_arbiter #(.N(8), .R(4), .CNT_W(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .op_count (op_count)
`ifdef INCR_RR_ARBITER_SATURATE_EN
      ,
      .sat_flag (sat_flag)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_cin    = '0;
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.resp_valid); end
      n_checks++; if (bus.resp_sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", bus.resp_sum); end
      n_checks++; if (bus.resp_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", bus.resp_cout); end
      n_checks++; if (bus.resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.resp_id); end
      n_checks++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_opcount: got %0d want 0", op_count); end
      n_checks++; if (dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_rrptr: got %0d want 0", dut.rr_ptr_q); end
      reset = 1'b0;
      tick();
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready: got %b want 0000", bus.req_ready); end
   endtask

   task automatic test_round_robin();
      bus.req_valid  = 4'b1111;
      bus.req_cin    = 4'b1111;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) bus.req_a[i*8 +: 8] = 8'(i);
      #1;
      for (int k = 0; k < 5; k++) begin
         int         g       = k % 4;
         logic [3:0] exp_rdy = 4'b0001 << g;
         n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.req_ready, exp_rdy); end
         tick();
         n_checks++; if (bus.resp_id !== 2'(g)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, bus.resp_id, g); end
         n_checks++; if (bus.resp_sum !== 8'(g + 1) || bus.resp_cout !== 1'b0) begin n_fail++; $display("FAIL rr_sum[%0d]: got %b_%h want 0_%h", k, bus.resp_cout, bus.resp_sum, 8'(g + 1)); end
         n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want 1", k, bus.resp_valid); end
      end
      bus.req_valid = '0;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_noreq_ready: got %b want 0000", bus.req_ready); end
      tick();
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain_valid: got %b want 0", bus.resp_valid); end
      n_checks++; if (op_count !== 16'd5) begin n_fail++; $display("FAIL rr_opcount: got %0d want 5", op_count); end
      n_checks++; if (dut.rr_ptr_q !== 2'd1) begin n_fail++; $display("FAIL rr_idle_ptr: got %0d want 1", dut.rr_ptr_q); end
   endtask

   task automatic test_overflow();
      clear_inputs();
      bus.resp_ready    = 1'b1;
      bus.req_valid     = 4'b0010;
      bus.req_a[15:8]   = 8'hFF;
      bus.req_cin       = 4'b0010;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL ovf_ready: got %b want 0010", bus.req_ready); end
      tick();
`ifdef INCR_RR_ARBITER_SATURATE_EN
      n_checks++; if (bus.resp_sum !== 8'hFF) begin n_fail++; $display("FAIL ovf_sum: got %h want ff", bus.resp_sum); end
      n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_sat: got %b want 1", sat_flag); end
`else
      n_checks++; if (bus.resp_sum !== 8'h00) begin n_fail++; $display("FAIL ovf_sum: got %h want 00", bus.resp_sum); end
`endif
      n_checks++; if (bus.resp_cout !== 1'b1) begin n_fail++; $display("FAIL ovf_cout: got %b want 1", bus.resp_cout); end
      n_checks++; if (bus.resp_id !== 2'd1) begin n_fail++; $display("FAIL ovf_id: got %0d want 1", bus.resp_id); end
      bus.req_valid = '0;
      tick();
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b want 0", bus.resp_valid); end
      n_checks++; if (op_count !== 16'd6) begin n_fail++; $display("FAIL ovf_opcount: got %0d want 6", op_count); end
`ifdef INCR_RR_ARBITER_SATURATE_EN
      n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_sat_clear: got %b want 0", sat_flag); end
`endif
   endtask

   task automatic test_backpressure();
      clear_inputs();
      bus.req_valid    = 4'b1000;
      bus.req_a[31:24] = 8'h41;
      #1;
      n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_fill_ready: got %b want 1000", bus.req_ready); end
      tick();
      n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_sum !== 8'h41 || bus.resp_id !== 2'd3) begin n_fail++; $display("FAIL bp_fill: got v%b %h id%0d want v1 41 id3", bus.resp_valid, bus.resp_sum, bus.resp_id); end
      bus.req_valid   = 4'b0101;
      bus.req_a[7:0]  = 8'h20;
      bus.req_a[23:16] = 8'h7F;
      bus.req_cin     = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, bus.req_ready); end
         n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_sum !== 8'h41) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b %h want v1 41", c, bus.resp_valid, bus.resp_sum); end
         n_checks++; if (dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL bp_ptr[%0d]: got %0d want 0", c, dut.rr_ptr_q); end
         tick();
      end
      bus.resp_ready = 1'b1;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0001", bus.req_ready); end
      tick();
      n_checks++; if (bus.resp_id !== 2'd0 || bus.resp_sum !== 8'h20) begin n_fail++; $display("FAIL bp_req0: got id%0d %h want id0 20", bus.resp_id, bus.resp_sum); end
      n_checks++; if (op_count !== 16'd7) begin n_fail++; $display("FAIL bp_opcount7: got %0d want 7", op_count); end
      n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_ready: got %b want 0100", bus.req_ready); end
      tick();
      n_checks++; if (bus.resp_id !== 2'd2 || bus.resp_sum !== 8'h80) begin n_fail++; $display("FAIL bp_req2: got id%0d %h want id2 80", bus.resp_id, bus.resp_sum); end
      bus.req_valid = '0;
      tick();
      n_checks++; if (bus.resp_valid !== 1'b0 || op_count !== 16'd9) begin n_fail++; $display("FAIL bp_final: got v%b cnt%0d want v0 cnt9", bus.resp_valid, op_count); end
   endtask

   task automatic test_sparse();
      clear_inputs();
      bus.resp_ready   = 1'b1;
      bus.req_valid    = 4'b0010;
      bus.req_a[15:8]  = 8'h05;
      bus.req_a[31:24] = 8'hA0;
      bus.req_cin      = 4'b1000;
      tick();
      n_checks++; if (dut.rr_ptr_q !== 2'd2 || bus.resp_id !== 2'd1) begin n_fail++; $display("FAIL sp_setup: got ptr%0d id%0d want ptr2 id1", dut.rr_ptr_q, bus.resp_id); end
      bus.req_valid = 4'b1010;
      #1;
      for (int k = 0; k < 3; k++) begin
         logic [1:0] eid  = (k == 1) ? 2'd1 : 2'd3;
         logic [7:0] esum = (k == 1) ? 8'h05 : 8'hA1;
         logic [3:0] erdy = 4'b0001 << eid;
         n_checks++; if (bus.req_ready !== erdy) begin n_fail++; $display("FAIL sp_ready[%0d]: got %b want %b", k, bus.req_ready, erdy); end
         tick();
         n_checks++; if (bus.resp_id !== eid || bus.resp_sum !== esum) begin n_fail++; $display("FAIL sp_result[%0d]: got id%0d %h want id%0d %h", k, bus.resp_id, bus.resp_sum, eid, esum); end
      end
      bus.req_valid = '0;
      tick();
      n_checks++; if (op_count !== 16'd13) begin n_fail++; $display("FAIL sp_opcount: got %0d want 13", op_count); end
   endtask

   task automatic test_reset_midop();
      clear_inputs();
      bus.req_valid    = 4'b0100;
      bus.req_a[23:16] = 8'h10;
      tick();
      n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_sum !== 8'h10 || bus.resp_id !== 2'd2) begin n_fail++; $display("FAIL rm_accept: got v%b %h id%0d want v1 10 id2", bus.resp_valid, bus.resp_sum, bus.resp_id); end
      reset = 1'b1;
      #1;
      n_checks++; if (bus.resp_valid !== 1'b0 || bus.resp_sum !== 8'h00) begin n_fail++; $display("FAIL rm_async: got v%b %h want v0 00", bus.resp_valid, bus.resp_sum); end
      n_checks++; if (op_count !== 16'd0 || dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL rm_state: got cnt%0d ptr%0d want cnt0 ptr0", op_count, dut.rr_ptr_q); end
      tick();
      reset = 1'b0;
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_held: got %b want 0", bus.resp_valid); end
      clear_inputs();
      bus.resp_ready   = 1'b1;
      bus.req_valid    = 4'b1010;
      bus.req_a[15:8]  = 8'h33;
      bus.req_cin      = 4'b0010;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_first_ready: got %b want 0010", bus.req_ready); end
      tick();
      n_checks++; if (bus.resp_id !== 2'd1 || bus.resp_sum !== 8'h34) begin n_fail++; $display("FAIL rm_first_result: got id%0d %h want id1 34", bus.resp_id, bus.resp_sum); end
   endtask

   task automatic test_op_count_wrap();
      reset = 1'b1;
      clear_inputs();
      tick();
      reset = 1'b0;
      bus.req_valid  = 4'b1111;
      bus.resp_ready = 1'b1;
      repeat (65536) @(posedge clk);
      #1;
      n_checks++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", op_count); end
      bus.req_valid = '0;
      tick();
      n_checks++; if (op_count !== 16'h0000 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap: got cnt%h v%b want cnt0000 v0", op_count, bus.resp_valid); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_overflow();
      test_backpressure();
      test_sparse();
      test_reset_midop();
      test_op_count_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
